ita_input_writer: RTL and testbench
===================================

# ita_input_writer

Streaming front-end that turns a narrow byte-beat input stream into full-row `write_port_t` transactions for ITA's input buffer. It sits between the system-side data mover and the input memory write port. It assembles `E` bytes per row from `E/BEAT_BYTES` beats and issues one write per row at consecutive addresses `0 .. seq_length-1`. It then pulses `done_o`.

## Interface
- `E`, default 64: bytes per row; equal to `ita_package::E`.
- `S`, default 64: maximum rows; equal to `ita_package::S`.
- `BEAT_BYTES`, default 8: bytes per input beat. `E % BEAT_BYTES == 0` is required, and elaboration fails otherwise.
- `WI`, default 8: byte width.
- Derived: `NBeats = E/BEAT_BYTES`; `AddrW = idx_width(S)`; `LenW = WO-2*WI` (10).
- `clk_i`  in  1  clock. One clock domain. Reset is asynchronous and active-low.
- `rst_ni`  in  1  asynchronous active-low reset.
- `start_i`  in  1  single-cycle start strobe. Ignored unless the block is idle.
- `seq_length_i`  in  LenW  number of rows to write. Sampled on an accepted `start_i`.
- `clear_i`  in  1  synchronous abort to IDLE. No `done_o` pulse.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  input beat accepted when high together with `in_valid_i`.
- `in_data_i`  in  BEAT_BYTES*WI  beat payload. Byte 0 is in the LSBs.
- `wr_valid_o`  out  1  write request valid.
- `wr_ready_i`  in  1  buffer accepts the write.
- `wr_port_o`  out  AddrW+E*WI  `write_port_t` as `{addr, data}`.
- `busy_o`  out  1  high in FILL or EMIT.
- `done_o`  out  1  one-cycle pulse after the last row is accepted, or after a zero-length start.
- `err_o`  out  1  sticky. Set when a start is rejected because `seq_length_i > S`. Cleared by the next accepted start or by `clear_i`.

## Operation
- States: IDLE, FILL, EMIT.
- **IDLE**, on `start_i`:
  - `seq_length_i == 0`: pulse `done_o`, stay in IDLE.
  - `seq_length_i > S`: set `err_o`, stay in IDLE, no `done_o`.
  - Otherwise: latch the length, clear `err_o`, set `row_cnt = 0` and `beat_cnt = 0`, go to FILL.
- **FILL**:
  - `in_ready_o = 1`.
  - Each handshake writes `in_data_i` into row-register bytes `[beat_cnt*BEAT_BYTES +: BEAT_BYTES]`, then increments `beat_cnt`.
  - The handshake with `beat_cnt == NBeats-1` goes to EMIT and resets `beat_cnt` to 0.
- **EMIT**:
  - `wr_valid_o = 1`, `wr_port_o.addr = row_cnt`, `wr_port_o.data` = row register. `in_ready_o = 0`.
  - On `wr_ready_i`: if `row_cnt == len-1`, go to IDLE and pulse `done_o` next cycle.
  - Otherwise increment `row_cnt` and go to FILL.
- `row_cnt` never wraps; the maximum value is `S-1`.
- The row register is not cleared between rows. Every byte is overwritten before EMIT.
- `start_i` in FILL or EMIT is ignored. It has no effect on the length or on `err_o`.
- `clear_i` has priority over every other event in every state.
  - It goes to IDLE and drops `wr_valid_o` and `in_ready_o` next cycle.
  - It zeroes the counters. No `done_o`.
  - `clear_i` together with `start_i` is resolved as clear only.
- Asynchronous reset mid-operation abandons the partial row. No write and no `done_o` are issued.

## Timing
- Reset values: `in_ready_o = 0`, `wr_valid_o = 0`, `wr_port_o = 0`, `busy_o = 0`, `done_o = 0`, `err_o = 0`. State is IDLE and all counters are 0.
- `in_ready_o`, `wr_valid_o` and `busy_o` are decoded from registered state only. There is no combinational path from `in_valid_i` or `wr_ready_i` to any output.
- An accepted start in cycle t gives `in_ready_o = 1` in cycle t+1.
- The last beat is accepted in cycle t, giving `wr_valid_o = 1` in cycle t+1.
- While `wr_valid_o && !wr_ready_i`, `wr_port_o` is held stable.
- `wr_valid_o` is never withdrawn without a handshake, except on `clear_i`.
- Best case per row is NBeats+1 cycles. Example: E=64, BEAT_BYTES=8 gives 9 cycles.
- `done_o` is asserted in the cycle after the final write handshake, for exactly one cycle.
- A zero-length start in cycle t gives `done_o` in cycle t+1.

## Test plan
- **Basic, 2 rows:**
  - Stimulus: start with `seq_length_i = 2`; 16 beats with byte value = global byte index (0..127); `wr_ready_i` tied high.
  - Required response: writes addr 0 with data bytes 0..63, then addr 1 with bytes 64..127. `done_o` pulses one cycle after the 2nd write. Total 1 + 18 cycles to `done_o`.
- **Backpressure and gaps:**
  - Stimulus: random `in_valid_i` gaps; `wr_ready_i` low for 5 cycles during each EMIT.
  - Required response: `wr_port_o` stable while stalled; no beat accepted during EMIT; data identical to the basic case.
- **Boundary lengths:**
  - Length 0: `done_o` the next cycle, no write.
  - Length S=64: 64 writes, addr 0..63, no wrap.
  - Length 65: `err_o` = 1, stays IDLE, no `done_o`. A following valid start clears `err_o`.
- **Ignored start:**
  - Stimulus: `start_i` with length 5 mid-FILL of a length-1 job.
  - Required response: exactly 1 write, then `done_o`.
- **Abort:**
  - `clear_i` after 3 beats of row 0: `in_ready_o = 0` next cycle, no write, no `done_o`. A new length-1 start then behaves as in the basic case.
  - `clear_i` asserted in the same cycle as `start_i`: block stays IDLE.
- **Async reset:**
  - Stimulus: drop `rst_ni` during EMIT with `wr_ready_i` low.
  - Required response: all outputs go to reset values immediately. After release, the block is IDLE and accepts a new start.

Source files
------------

// File: rtl/ita_input_writer.sv
// ITA input writer: packs narrow input beats into full rows and
// writes them to the input buffer at addresses 0 .. len-1.
module ita_input_writer #(
  parameter int unsigned E          = 64,
  parameter int unsigned S          = 64,
  parameter int unsigned BEAT_BYTES = 8,
  parameter int unsigned WI         = 8,
  parameter int unsigned LenW       = 10,
  localparam int unsigned NBeats    = E / BEAT_BYTES,
  localparam int unsigned AddrW     = (S > 1) ? $clog2(S) : 1,
  localparam int unsigned BeatW     = (NBeats > 1) ? $clog2(NBeats) : 1,
  localparam int unsigned BeatBits  = BEAT_BYTES * WI,
  localparam int unsigned DataW     = E * WI,
  localparam int unsigned PortW     = AddrW + DataW
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [LenW-1:0]     seq_length_i,
  input  logic                clear_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [BeatBits-1:0] in_data_i,
  output logic                wr_valid_o,
  input  logic                wr_ready_i,
  output logic [PortW-1:0]    wr_port_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  if (E % BEAT_BYTES != 0) begin : g_bad_cfg
    $error("E must be a multiple of BEAT_BYTES");
  end

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    EMIT
  } state_e;

  state_e             r_state;
  state_e             w_next;
  logic [LenW-1:0]    r_len;
  logic [AddrW-1:0]   r_row;
  logic [BeatW-1:0]   r_beat;
  logic [DataW-1:0]   r_data;
  logic               r_done;
  logic               r_err;

  logic w_idle_start;
  logic w_len_zero;
  logic w_len_big;
  logic w_start_ok;
  logic w_beat_hs;
  logic w_wr_hs;
  logic w_last_beat;
  logic w_last_row;

  assign w_idle_start = (r_state == IDLE) && start_i;
  assign w_len_zero   = (seq_length_i == '0);
  assign w_len_big    = (seq_length_i > LenW'(S));
  assign w_start_ok   = w_idle_start && !w_len_zero && !w_len_big;
  assign w_beat_hs    = (r_state == FILL) && in_valid_i;
  assign w_wr_hs      = (r_state == EMIT) && wr_ready_i;
  assign w_last_beat  = (r_beat == BeatW'(NBeats - 1));
  assign w_last_row   = (LenW'(r_row) == r_len - LenW'(1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear_i) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_start_ok) w_next = FILL;
        FILL:    if (w_beat_hs && w_last_beat) w_next = EMIT;
        EMIT:    if (w_wr_hs) w_next = w_last_row ? IDLE : FILL;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_len  <= '0;
      r_row  <= '0;
      r_beat <= '0;
      r_data <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else if (clear_i) begin
      r_row  <= '0;
      r_beat <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_idle_start) begin
        if (w_len_zero) begin
          r_done <= 1'b1;
        end else if (w_len_big) begin
          r_err <= 1'b1;
        end else begin
          r_len  <= seq_length_i;
          r_err  <= 1'b0;
          r_row  <= '0;
          r_beat <= '0;
        end
      end
      // Row register is never cleared; every beat slot is rewritten per row
      if (w_beat_hs) begin
        r_data[int'(r_beat) * BeatBits +: BeatBits] <= in_data_i;
        r_beat <= w_last_beat ? '0 : r_beat + BeatW'(1);
      end
      if (w_wr_hs) begin
        if (w_last_row) begin
          r_done <= 1'b1;
          r_row  <= '0;
        end else begin
          r_row <= r_row + AddrW'(1);
        end
      end
    end
  end

  assign in_ready_o = (r_state == FILL);
  assign wr_valid_o = (r_state == EMIT);
  assign busy_o     = (r_state != IDLE);
  assign done_o     = r_done;
  assign err_o      = r_err;
  assign wr_port_o  = {r_row, r_data};

endmodule

// File: tb/tb_ita_input_writer.sv
// Bench for ita_input_writer: random beats/backpressure checked
// against a row-array reference of the expected write stream.
module tb_ita_input_writer;

  localparam int E     = 64;
  localparam int S     = 64;
  localparam int BB    = 8;
  localparam int WI    = 8;
  localparam int LenW  = 10;
  localparam int NB    = E / BB;
  localparam int AddrW = 6;
  localparam int PortW = AddrW + E * WI;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              start_i = 1'b0;
  logic [LenW-1:0]   seq_length_i = '0;
  logic              clear_i = 1'b0;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [BB*WI-1:0]  in_data_i = '0;
  logic              wr_valid_o;
  logic              wr_ready_i = 1'b1;
  logic [PortW-1:0]  wr_port_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  logic [7:0] mem [S*E];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ita_input_writer #(
    .E(E), .S(S), .BEAT_BYTES(BB), .WI(WI), .LenW(LenW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .start_i(start_i),
    .seq_length_i(seq_length_i),
    .clear_i(clear_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .in_data_i(in_data_i),
    .wr_valid_o(wr_valid_o),
    .wr_ready_i(wr_ready_i),
    .wr_port_o(wr_port_o),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [1023:0] got,
                     input logic [1023:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic fill(input bit basic);
    for (int i = 0; i < S * E; i++)
      mem[i] = basic ? i[7:0] : 8'($urandom);
  endtask

  function automatic logic [PortW-1:0] exp_port(input int r);
    logic [E*WI-1:0]  d;
    logic [AddrW-1:0] a;
    int rr;
    rr = r % S;
    a  = rr[AddrW-1:0];
    for (int b = 0; b < E; b++) d[b*8 +: 8] = mem[rr*E + b];
    return {a, d};
  endfunction

  task automatic beat_data(input int bi);
    for (int k = 0; k < BB; k++)
      in_data_i[k*8 +: 8] = mem[(bi*BB + k) % (S*E)];
  endtask

  task automatic run_job(input int L, input bit gaps, input bit bp,
                         input bit ign);
    int bi, wi, cyc, stall;
    bit fin;
    bi = 0; wi = 0; cyc = 0; stall = 0; fin = 0;
    @(negedge clk);
    start_i = 1'b1; seq_length_i = LenW'(L); in_valid_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0; cyc = 1;
    chk("start_rdy", in_ready_o, 1);
    chk("err_clr", err_o, 0);
    while (!fin && cyc < 6000) begin
      if (done_o) begin
        fin = 1;
        chk("rows", wi, L);
        chk("beats", bi, L * NB);
        if (!gaps && !bp) chk("latency", cyc, 1 + L * (NB + 1));
      end else begin
        chk("busy", busy_o, 1);
        chk("excl", in_ready_o & wr_valid_o, 0);
        start_i = ign && (bi == 3);
        seq_length_i = 10'd5;
        if (in_ready_o) begin
          in_valid_i = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
          beat_data(bi);
          if (in_valid_i) bi++;
        end else begin
          in_valid_i = 1'($urandom_range(0, 1));
          in_data_i = {$urandom, $urandom};
        end
        if (wr_valid_o) begin
          chk("wr_port", wr_port_o, exp_port(wi));
          if (bp && stall < 5) begin
            wr_ready_i = 1'b0; stall++;
          end else begin
            wr_ready_i = 1'b1; stall = 0; wi++;
          end
        end else begin
          wr_ready_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start_i = 1'b0; in_valid_i = 1'b0; wr_ready_i = 1'b1;
    @(negedge clk);
    chk("done_pulse", done_o, 0);
    chk("idle", busy_o, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy", in_ready_o, 0);
    chk("rst_wrv", wr_valid_o, 0);
    chk("rst_port", wr_port_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", busy_o, 0);

    fill(1);
    run_job(2, 0, 0, 0);
    run_job(2, 1, 1, 0);

    @(negedge clk);
    start_i = 1'b1; seq_length_i = '0;
    @(negedge clk);
    start_i = 1'b0;
    chk("len0_done", done_o, 1);
    chk("len0_wrv", wr_valid_o, 0);
    chk("len0_busy", busy_o, 0);
    @(negedge clk);
    chk("len0_pulse", done_o, 0);

    fill(0);
    run_job(S, 1, 1, 0);

    @(negedge clk);
    start_i = 1'b1; seq_length_i = 10'd65;
    @(negedge clk);
    start_i = 1'b0;
    chk("big_err", err_o, 1);
    chk("big_busy", busy_o, 0);
    chk("big_done", done_o, 0);
    @(negedge clk);
    chk("big_err_hold", err_o, 1);
    chk("big_done2", done_o, 0);
    fill(0);
    run_job(1, 0, 0, 0);

    fill(0);
    run_job(1, 1, 0, 1);

    @(negedge clk);
    start_i = 1'b1; seq_length_i = 10'd1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1; in_data_i = {$urandom, $urandom};
      @(negedge clk);
    end
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; in_valid_i = 1'b0;
    chk("clr_rdy", in_ready_o, 0);
    chk("clr_busy", busy_o, 0);
    chk("clr_wrv", wr_valid_o, 0);
    chk("clr_done", done_o, 0);
    repeat (3) @(negedge clk);
    chk("clr_done_late", done_o, 0);
    fill(1);
    run_job(1, 0, 0, 0);

    @(negedge clk);
    start_i = 1'b1; clear_i = 1'b1; seq_length_i = 10'd3;
    @(negedge clk);
    start_i = 1'b0; clear_i = 1'b0;
    chk("clrst_busy", busy_o, 0);
    chk("clrst_rdy", in_ready_o, 0);
    chk("clrst_done", done_o, 0);

    for (int j = 0; j < 4; j++) begin
      fill(0);
      run_job($urandom_range(1, 6), 1, 1'($urandom_range(0, 1)), 0);
    end

    fill(0);
    @(negedge clk);
    start_i = 1'b1; seq_length_i = 10'd1; wr_ready_i = 1'b0;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 60 && !wr_valid_o; i++) begin
      in_valid_i = 1'b1; beat_data(i);
      @(negedge clk);
    end
    in_valid_i = 1'b0;
    chk("emit_reached", wr_valid_o, 1);
    @(negedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_rdy", in_ready_o, 0);
    chk("arst_wrv", wr_valid_o, 0);
    chk("arst_port", wr_port_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    chk("arst_err", err_o, 0);
    @(negedge clk);
    rst_ni = 1'b1; wr_ready_i = 1'b1;
    @(negedge clk);
    chk("arst_idle", busy_o, 0);
    fill(0);
    run_job(2, 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
